// File: rtl/rt_input_buffer_if.sv
// ---------------------------------------------------------------------------
// rt_input_buffer_if
// Groups the flit handshake signals of one router input stage.
//   in_req/in_data/in_ack       : upstream req/ack flit link into the buffer
//   out_req/out_data/out_dir/   : head flit, its XY route and the downstream
//   out_ack                       consume strobe
//   count                       : buffer occupancy
// Modports: slave = the buffer itself, master = upstream/downstream side.
// ---------------------------------------------------------------------------
interface rt_input_buffer_if #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
);
  logic                    in_req;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ack;
  logic                    out_req;
  logic [WIDTH-1:0]        out_data;
  logic [2:0]              out_dir;
  logic                    out_ack;
  logic [$clog2(DEPTH):0]  count;

  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, out_dir, count
  );

  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, out_dir, count
  );
endinterface

// File: rtl/rt_input_buffer.sv
// ---------------------------------------------------------------------------
// rt_input_buffer
// Per-port mesh router input stage: a DEPTH-entry flit FIFO that computes the
// XY dimension-order output direction of each flit as it is enqueued and
// presents the head flit plus direction to the switch stage.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (discards all buffered flits)
//   bus  : rt_input_buffer_if.slave
//          in_req/in_data/in_ack   upstream flit handshake
//          out_req/out_data/out_dir/out_ack  head flit handshake
//          count                   occupancy
// Direction encoding: 0=N, 1=E, 2=S, 3=W, 4=LOCAL.
// ---------------------------------------------------------------------------
module rt_input_buffer #(
  parameter int WIDTH   = 512,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic               clk,
  input  logic               rst,
  rt_input_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

  localparam logic [2:0] DIR_N     = 3'd0;
  localparam logic [2:0] DIR_E     = 3'd1;
  localparam logic [2:0] DIR_S     = 3'd2;
  localparam logic [2:0] DIR_W     = 3'd3;
  localparam logic [2:0] DIR_LOCAL = 3'd4;

  // X is resolved before Y; mesh bounds are trusted to the source.
  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [2:0] dir;
    if (dx > MX)      dir = DIR_E;
    else if (dx < MX) dir = DIR_W;
    else if (dy > MY) dir = DIR_S;
    else if (dy < MY) dir = DIR_N;
    else              dir = DIR_LOCAL;
    return dir;
  endfunction

  logic [WIDTH-1:0] r_mem     [DEPTH];
  logic [2:0]       r_dir_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_in_ack;
  logic             w_out_req;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_route;

  // Handshake flags depend on registered occupancy only, so there is no
  // combinational path from out_ack to in_ack (no full-bypass).
  assign w_in_ack  = (r_count != CW'(DEPTH));
  assign w_out_req = (r_count != '0);
  assign w_push    = bus.in_req & w_in_ack;
  assign w_pop     = w_out_req & bus.out_ack;

  assign w_route = xy_route(bus.in_data[COORD_W-1:0],
                            bus.in_data[2*COORD_W-1:COORD_W]);

  // Stage boundary: enqueue -- control state, async-cleared so out_req drops
  // together with rst rather than at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage holds data only and is left unreset; the route is captured with
  // the flit so the head direction is ready without recomputation.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]     <= bus.in_data;
      r_dir_mem[r_wr_ptr] <= w_route;
    end
  end

  // Stage boundary: head presentation straight from the entry at rd_ptr.
  assign bus.in_ack   = w_in_ack;
  assign bus.out_req  = w_out_req;
  assign bus.out_data = r_mem[r_rd_ptr];
  assign bus.out_dir  = r_dir_mem[r_rd_ptr];
  assign bus.count    = r_count;

endmodule
